// File: rtl/uart_rx_multi_if.sv
// ---------------------------------------------------------------------------
// uart_rx_multi_if
// Stream bundle carrying received UART words out of uart_rx_multi.
//   m_data       : head-of-FIFO data word
//   m_frame_err  : head entry had a stop bit sampled 0
//   m_parity_err : head entry failed the parity check
//   m_valid      : FIFO not empty
//   m_ready      : consumer accepts the head entry
// master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_multi_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_frame_err;
    logic                 m_parity_err;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_frame_err,
        output m_parity_err,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_frame_err,
        input  m_parity_err,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_multi.sv
// ---------------------------------------------------------------------------
// uart_rx_multi
// Oversampling UART receiver running in the system_clk domain, with
// configurable frame format (5-9 data bits, none/odd/even parity, 1 or 2
// stop bits), 3-sample majority voting, framing/parity/break detection and a
// small output FIFO.
// Ports:
//   system_clk  : clock
//   reset       : synchronous, active-low reset
//   i_rx        : asynchronous serial line, idle high
//   m_if        : output stream (data, error flags, valid/ready)
//   o_overrun   : 1-cycle pulse, completed frame dropped (FIFO full)
//   o_break_det : 1-cycle pulse, line break detected
//   o_busy      : receive FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_multi #(
    parameter int unsigned CLK_DIV    = 54,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    system_clk,
    input  logic                    reset,
    input  logic                    i_rx,
    uart_rx_multi_if.master         m_if,
    output logic                    o_overrun,
    output logic                    o_break_det,
    output logic                    o_busy
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TC_SMP0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_SMP1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TC_DEC    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TC_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_t;

    // Receive path state
    logic [1:0]           r_sync;
    state_t               r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [TW-1:0]        r_tc;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [1:0]           r_smp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_all_zero;
    logic                 r_overrun;
    logic                 r_break_det;

    // FIFO state; entry layout is {frame_err, parity_err, data}
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;

    logic                 w_rxs;
    logic                 w_tick;
    logic                 w_decide;
    logic                 w_wrap;
    logic                 w_bit;
    logic                 w_last_stop;
    logic                 w_break;
    logic                 w_push;
    logic                 w_par_err;
    logic                 w_frame_err;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic [EW-1:0]        w_head;

    assign w_rxs    = r_sync[1];
    assign w_tick   = (r_state != StIdle) && (r_clk_cnt == CNT_LAST);
    assign w_decide = w_tick && (r_tc == TC_DEC);
    assign w_wrap   = w_tick && (r_tc == TC_LAST);

    // Third sample is the live line value on the decision tick
    assign w_bit = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rxs) | (r_smp[1] & w_rxs);

    // Odd parity: data+parity XOR must be 1; even: must be 0
    assign w_par_err = (PARITY == 1) ? ~(^r_shift ^ w_bit) : (^r_shift ^ w_bit);

    assign w_last_stop = (r_state == StStop) && w_decide && (r_stop_idx == STOP_LAST);
    assign w_break     = w_last_stop && r_all_zero && !w_bit;
    assign w_push      = w_last_stop && !w_break;
    assign w_frame_err = r_frame_err | ~w_bit;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]});
    assign w_pop   = !w_empty && m_if.m_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign m_if.m_valid      = !w_empty;
    assign m_if.m_data       = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign m_if.m_parity_err = w_empty ? 1'b0 : w_head[DATA_BITS];
    assign m_if.m_frame_err  = w_empty ? 1'b0 : w_head[DATA_BITS+1];
    assign o_overrun         = r_overrun;
    assign o_break_det       = r_break_det;
    assign o_busy            = (r_state != StIdle);

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            r_sync       <= 2'b11;
            r_state      <= StIdle;
            r_clk_cnt    <= '0;
            r_tc         <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_smp        <= 2'b11;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_all_zero   <= 1'b1;
            r_overrun    <= 1'b0;
            r_break_det  <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], i_rx};
            r_overrun   <= w_push && w_full && !w_pop;
            r_break_det <= w_break;

            // Divider stays at 0 while idle so tick phase aligns to the start edge
            if (r_state == StIdle || w_tick) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + CW'(1);
            end

            if (w_tick) begin
                r_tc <= (r_tc == TC_LAST) ? '0 : r_tc + TW'(1);
                if (r_tc == TC_SMP0) r_smp[0] <= w_rxs;
                if (r_tc == TC_SMP1) r_smp[1] <= w_rxs;
            end

            unique case (r_state)
                StIdle: begin
                    r_tc <= '0;
                    if (!w_rxs) begin
                        r_state      <= StStart;
                        r_bit_idx    <= '0;
                        r_stop_idx   <= 1'b0;
                        r_frame_err  <= 1'b0;
                        r_parity_err <= 1'b0;
                        r_all_zero   <= 1'b1;
                    end
                end
                StStart: begin
                    if (w_decide && w_bit) begin
                        r_state <= StIdle;
                    end else if (w_wrap) begin
                        r_state <= StData;
                    end
                end
                StData: begin
                    if (w_decide) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        if (w_bit) r_all_zero <= 1'b0;
                    end
                    if (w_wrap) begin
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= (PARITY != 0) ? StParity : StStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end
                end
                StParity: begin
                    if (w_decide) begin
                        r_parity_err <= w_par_err;
                        if (w_bit) r_all_zero <= 1'b0;
                    end
                    if (w_wrap) r_state <= StStop;
                end
                StStop: begin
                    if (w_decide) begin
                        if (!w_bit) r_frame_err <= 1'b1;
                        if (w_bit) r_all_zero <= 1'b0;
                        // Leave on the last decision rather than the bit end so a
                        // slightly fast sender's next start edge is not missed
                        if (r_stop_idx == STOP_LAST) begin
                            r_state <= w_break ? StBreak : StIdle;
                        end
                    end else if (w_wrap) begin
                        r_stop_idx <= r_stop_idx + 1'b1;
                    end
                end
                StBreak: begin
                    if (w_rxs) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge system_clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= {w_frame_err, r_parity_err, r_shift};
        end
    end

endmodule

// File: doc/uart_rx_multi.md
# uart_rx_multi

Parametrised UART receiver that runs entirely in the `system_clk` domain and derives its own oversampling tick, so no separate UART clock is needed. Frame format is configurable: 5–9 data bits, none/odd/even parity, and 1 or 2 stop bits. Each bit is sampled with a 3-sample majority vote, and framing errors, parity errors and line breaks are detected. Received words are buffered in a small FIFO with a valid/ready output, so the receiver sits between the pad synchroniser-free `rx` pin and any stream consumer such as a command parser or DMA.

## Interface
- `CLK_DIV`, 54: `system_clk` cycles per oversample tick (≥2).
- `OVERSAMPLE`, 16: ticks per bit; even, 8–32.
- `DATA_BITS`, 8: data bits per frame, 5–9, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries; power of two, ≥2.

- `system_clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `m_data`  out  DATA_BITS  head-of-FIFO data word.
- `m_frame_err`  out  1  head entry had a stop bit sampled 0.
- `m_parity_err`  out  1  head entry failed the parity check (always 0 when PARITY=0).
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts the head entry.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- `break_det`  out  1  one-cycle pulse: break condition detected.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Input conditioning**
  - `rx` passes through a 2-flop synchroniser whose flops reset to 1; the result is `rxs`.
  - All logic below uses `rxs`.
- **Tick generator**
  - Counter `0..CLK_DIV-1`; a tick fires when it wraps.
  - Held at 0 in IDLE, so phase is aligned to the start edge.
- **Tick and bit counters**
  - A tick counter `tc` (0..OVERSAMPLE-1) and a bit index advance on ticks.
  - Samples are taken at ticks `tc = OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1`.
  - The bit value is the majority of the 3 samples, decided at `tc = OVERSAMPLE/2+1`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE → START when `rxs == 0`.
  - START: if the majority is 1, it was a false start → IDLE with no push. Otherwise → DATA at the end of the bit (`tc` wrap).
  - DATA: shift the decided bits in LSB first. After DATA_BITS bits → PARITY if PARITY≠0, else STOP.
  - PARITY: check odd parity (XOR over data+parity = 1) or even parity (= 0).
  - STOP: each stop bit sampled 0 sets the frame error. At the decision of the last stop bit:
    - If all data bits, the parity bit (if present) and every stop bit are 0 → pulse `break_det`, push nothing, go to BREAK.
    - Else push {data, frame_err, parity_err} and go to IDLE immediately. Do not wait for the end of the stop bit; this tolerates up to half a bit of sender clock mismatch on back-to-back frames.
  - BREAK → IDLE once `rxs == 1`.
- **FIFO**
  - Push happens on the cycle after the final decision.
  - Pop happens when `m_valid && m_ready`.
  - Push and pop in the same cycle are both performed, and occupancy is unchanged.
  - A push while the FIFO is full (and no pop that cycle) drops the new frame and pulses `overrun`; stored entries are unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - `m_data` and the error flags are read directly from the head entry.
- **Reset**
  - Active in any state, including mid-frame: the partial frame is discarded and the FIFO is emptied.
  - `m_valid`, `m_data`, `m_frame_err`, `m_parity_err`, `overrun`, `break_det` and `busy` all reset to 0.
  - The FSM returns to IDLE.

## Timing
- **Input latency:** a change on `rx` appears on `rxs` 2 cycles later.
- **T0** = the first cycle IDLE sees `rxs == 0`. Tick k fires at T0 + k·CLK_DIV.
- **Bit period** = CLK_DIV·OVERSAMPLE cycles.
- **Bit decision point:** bit n (start = 0) is decided at tick n·OVERSAMPLE + OVERSAMPLE/2 + 2.
- **Output latency:** `m_valid` rises 1 cycle after the decision of the last stop bit. For the defaults (8N1), that is T0 + (9·16+10)·54 + 1.
- **Pulse timing:** `overrun` and `break_det` are asserted in the same cycle a push would have occurred.
- **Back-to-back frames:** the next start edge can be accepted the cycle after the push.
- **FIFO read:** throughput is one entry per cycle; there is no combinational path from `m_ready` to `m_valid` within the same cycle.

## Test plan
- **8N1 single byte.** CLK_DIV=4, 8N1: send 0xA5 → one entry, `m_data`=0xA5, both error flags 0, `m_valid` at T0+617.
- **Odd parity.** 8O1: send 0x3C with a correct parity bit of 1 → `m_parity_err`=0. Send 0x3C with parity bit 0 → `m_parity_err`=1 and `m_data`=0x3C.
- **Framing error and 2-stop mode.**
  - Send 0x55 with the stop bit forced to 0 → `m_frame_err`=1, no `break_det`.
  - STOP_BITS=2 with the second stop bit forced to 0 → `m_frame_err`=1.
- **Noise rejection.**
  - A 1-tick low glitch on the idle line → no push and `busy` returns to 0.
  - A 1-tick inverted glitch at a bit centre → the majority vote recovers the correct byte.
- **Overrun and flow control.** FIFO_DEPTH=4, `m_ready`=0: send 5 bytes 0x01..0x05 → one `overrun` pulse on byte 5. Then raise `m_ready` → 0x01..0x04 are read in order.
- **Break, reset and restart.**
  - Hold `rx` low for 12 bit periods → exactly one `break_det` pulse and no entry.
  - Assert `reset` mid-frame → all outputs 0 the next cycle.
  - A subsequent 0x7E frame is received correctly.
